countdown_ctrl: RTL and testbench

//  Front-panel sequencer for the countdown timer datapath. Edits the target

---
 rtl/countdown_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_countdown_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// Front-panel sequencer for the countdown timer: HH:MM:SS editing, datapath strobes, alarm phase.
// Define AUTO_RELOAD_EN to restart the countdown automatically when the alarm times out.
module countdown_ctrl #(
    parameter int unsigned ALARM_CYCLES = 500_000_000,
    parameter int unsigned MAX_HOURS    = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic        btn_clear,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        cd_buzzer_i,
    output logic [16:0] tar_sec,
    output logic        init_en,
    output logic        run,
    output logic        pause,
    output logic        clear,
    output logic [1:0]  mode,
    output logic [1:0]  sel_field,
    output logic        alarm_o,
    output logic [2:0]  dbg_state_o
);
    // Interface: buttons and strobes are single-cycle pulses with no valid/ready backpressure.
    localparam int CW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;

    localparam logic [2:0] ST_SET     = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_PAUSED  = 3'd3;
    localparam logic [2:0] ST_ALARM   = 3'd4;
`ifdef AUTO_RELOAD_EN
    localparam logic [2:0] ST_AR_INIT = 3'd5;
    localparam logic [2:0] ST_AR_RUN  = 3'd6;
`endif

    localparam logic [1:0] MODE_SET    = 2'd0;
    localparam logic [1:0] MODE_RUN    = 2'd1;
    localparam logic [1:0] MODE_PAUSED = 2'd2;
    localparam logic [1:0] MODE_ALARM  = 2'd3;

    localparam logic [2:0] A_NONE  = 3'd0;
    localparam logic [2:0] A_CLEAR = 3'd1;
    localparam logic [2:0] A_PAUSE = 3'd2;
    localparam logic [2:0] A_START = 3'd3;
    localparam logic [2:0] A_SEL   = 3'd4;
    localparam logic [2:0] A_INC   = 3'd5;
    localparam logic [2:0] A_DEC   = 3'd6;

    localparam logic [5:0]    H_MAX     = 6'(MAX_HOURS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(ALARM_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    sel_q, sel_d;
    logic [5:0]    h_q, h_d, m_q, m_d, s_q, s_d;
    logic [16:0]   tar_q, tar_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          alarm_q, alarm_d;
    logic          init_q, init_d, run_q, run_d, pause_q, pause_d, clear_q, clear_d;
    logic [2:0]    act;

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] vmax, input logic up);
        if (up) return (v == vmax) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? vmax : v - 6'd1;
    endfunction

    // Only the highest-priority pulse is seen by the state logic.
    always_comb begin
        if (btn_clear)      act = A_CLEAR;
        else if (btn_pause) act = A_PAUSE;
        else if (btn_start) act = A_START;
        else if (btn_sel)   act = A_SEL;
        else if (btn_inc)   act = A_INC;
        else if (btn_dec)   act = A_DEC;
        else                act = A_NONE;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        alarm_d = alarm_q;
        init_d  = 1'b0;
        run_d   = 1'b0;
        pause_d = 1'b0;
        clear_d = 1'b0;
        case (state_q)
            ST_SET: begin
                case (act)
                    A_CLEAR: clear_d = 1'b1;
                    A_START: begin
                        if (tar_q != 17'd0) begin
                            init_d  = 1'b1;
                            state_d = ST_LOAD;
                        end
                    end
                    A_SEL: sel_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                    A_INC, A_DEC: begin
                        case (sel_q)
                            2'd0:    s_d = step(s_q, 6'd59, act == A_INC);
                            2'd1:    m_d = step(m_q, 6'd59, act == A_INC);
                            default: h_d = step(h_q, H_MAX, act == A_INC);
                        endcase
                    end
                    default: ;
                endcase
            end
            // Buttons are ignored during the one-cycle gap between load and run.
            ST_LOAD: begin
                run_d   = 1'b1;
                mode_d  = MODE_RUN;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (act == A_CLEAR) begin
                    clear_d = 1'b1;
                    mode_d  = MODE_SET;
                    state_d = ST_SET;
                end else if (act == A_PAUSE) begin
                    pause_d = 1'b1;
                    mode_d  = MODE_PAUSED;
                    state_d = ST_PAUSED;
                end else if (cd_buzzer_i) begin
                    cnt_d   = '0;
                    alarm_d = 1'b1;
                    mode_d  = MODE_ALARM;
                    state_d = ST_ALARM;
                end
            end
            ST_PAUSED: begin
                if (act == A_CLEAR) begin
                    clear_d = 1'b1;
                    mode_d  = MODE_SET;
                    state_d = ST_SET;
                end else if (act == A_START) begin
                    run_d   = 1'b1;
                    mode_d  = MODE_RUN;
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                cnt_d = cnt_q + CW'(1);
                if (act != A_NONE || cnt_q == CNT_LAST) begin
                    clear_d = 1'b1;
                    alarm_d = 1'b0;
                    mode_d  = MODE_SET;
                    state_d = ST_SET;
`ifdef AUTO_RELOAD_EN
                    if (act == A_NONE) state_d = ST_AR_INIT;
`endif
                end
            end
`ifdef AUTO_RELOAD_EN
            ST_AR_INIT: begin
                init_d  = 1'b1;
                state_d = ST_AR_RUN;
            end
            ST_AR_RUN: begin
                run_d   = 1'b1;
                mode_d  = MODE_RUN;
                state_d = ST_RUN;
            end
`endif
            default: begin
                alarm_d = 1'b0;
                mode_d  = MODE_SET;
                state_d = ST_SET;
            end
        endcase
        tar_d = 17'(h_d) * 17'd3600 + 17'(m_d) * 17'd60 + 17'(s_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SET;
            mode_q  <= MODE_SET;
            sel_q   <= 2'd0;
            h_q     <= 6'd0;
            m_q     <= 6'd0;
            s_q     <= 6'd0;
            tar_q   <= 17'd0;
            cnt_q   <= '0;
            alarm_q <= 1'b0;
            init_q  <= 1'b0;
            run_q   <= 1'b0;
            pause_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            tar_q   <= tar_d;
            cnt_q   <= cnt_d;
            alarm_q <= alarm_d;
            init_q  <= init_d;
            run_q   <= run_d;
            pause_q <= pause_d;
            clear_q <= clear_d;
        end
    end

    assign tar_sec     = tar_q;
    assign init_en     = init_q;
    assign run         = run_q;
    assign pause       = pause_q;
    assign clear       = clear_q;
    assign mode        = mode_q;
    assign sel_field   = sel_q;
    assign alarm_o     = alarm_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus randomized pulses against a behavioural model.
module tb_countdown_ctrl;
    localparam int ALARM = 10;
    localparam int MAXH  = 23;
    localparam int W     = 26;

    localparam logic [5:0] B_NONE = 6'b000000;
    localparam logic [5:0] B_CLR  = 6'b100000;
    localparam logic [5:0] B_PAU  = 6'b010000;
    localparam logic [5:0] B_STA  = 6'b001000;
    localparam logic [5:0] B_SEL  = 6'b000100;
    localparam logic [5:0] B_INC  = 6'b000010;
    localparam logic [5:0] B_DEC  = 6'b000001;

    localparam int F_TAR = 0, F_INIT = 1, F_RUN = 2, F_PAUSE = 3;
    localparam int F_CLEAR = 4, F_MODE = 5, F_SEL = 6, F_ALARM = 7;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        btn_start = 0, btn_pause = 0, btn_clear = 0;
    logic        btn_sel = 0, btn_inc = 0, btn_dec = 0, cd_buzzer_i = 0;
    logic [16:0] tar_sec;
    logic        init_en, run, pause, clear, alarm_o;
    logic [1:0]  mode, sel_field;
    logic [2:0]  dbg_state;

    countdown_ctrl #(.ALARM_CYCLES(ALARM), .MAX_HOURS(MAXH)) dut (
        .clk(clk), .rst(rst),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
        .btn_sel(btn_sel), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cd_buzzer_i(cd_buzzer_i),
        .tar_sec(tar_sec), .init_en(init_en), .run(run), .pause(pause), .clear(clear),
        .mode(mode), .sel_field(sel_field), .alarm_o(alarm_o), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // behavioural model: panel fields, mode, alarm age, and queued future strobe frames
    int m_mode = 0, hh = 0, mm = 0, ss = 0, fsel = 0, alarm_done = 0;
    typedef struct { bit init; bit run; bit clr; int mode; } frame_t;
    frame_t pend_q[$];
    logic [W-1:0] exp_q[$];

    typedef struct { string name; int field; int value; } pin_t;
    pin_t lit_q[$];

    string fnames[8] = '{"tar_sec", "init_en", "run", "pause", "clear", "mode", "sel_field", "alarm_o"};

    function automatic int tar_of();
        return hh * 3600 + mm * 60 + ss;
    endfunction

    task automatic bump(input int d);
        case (fsel)
            0:       ss = (ss + d + 60) % 60;
            1:       mm = (mm + d + 60) % 60;
            default: hh = (hh + d + MAXH + 1) % (MAXH + 1);
        endcase
    endtask

    task automatic model_step(input logic r, input logic [5:0] b, input logic buz);
        int act;
        bit ei, er, ep, ec;
        frame_t f;
        ei = 0; er = 0; ep = 0; ec = 0;
        act = 0;
        for (int i = 5; i >= 0; i--) if (act == 0 && b[i]) act = 6 - i;
        if (r) begin
            m_mode = 0; hh = 0; mm = 0; ss = 0; fsel = 0; alarm_done = 0;
            pend_q.delete();
        end else if (pend_q.size() != 0) begin
            f = pend_q.pop_front();
            ei = f.init; er = f.run; ec = f.clr; m_mode = f.mode;
        end else begin
            case (m_mode)
                0: case (act)
                    1: ec = 1;
                    3: if (tar_of() != 0) begin
                        ei = 1;
                        pend_q.push_back('{init: 1'b0, run: 1'b1, clr: 1'b0, mode: 1});
                    end
                    4: fsel = (fsel + 1) % 3;
                    5: bump(1);
                    6: bump(-1);
                    default: ;
                endcase
                1: if (act == 1) begin ec = 1; m_mode = 0; end
                   else if (act == 2) begin ep = 1; m_mode = 2; end
                   else if (buz) begin m_mode = 3; alarm_done = 0; end
                2: if (act == 1) begin ec = 1; m_mode = 0; end
                   else if (act == 3) begin er = 1; m_mode = 1; end
                default: begin
                    alarm_done++;
                    if (act != 0) begin
                        ec = 1; m_mode = 0;
                    end else if (alarm_done == ALARM) begin
                        ec = 1; m_mode = 0;
`ifdef AUTO_RELOAD_EN
                        pend_q.push_back('{init: 1'b1, run: 1'b0, clr: 1'b0, mode: 0});
                        pend_q.push_back('{init: 1'b0, run: 1'b1, clr: 1'b0, mode: 1});
`endif
                    end
                end
            endcase
        end
        exp_q.push_back({17'(tar_of()), ei, er, ep, ec, 2'(m_mode), 2'(fsel), (m_mode == 3)});
    endtask

    function automatic int fld(input logic [W-1:0] v, input int k);
        case (k)
            F_TAR:   return int'(v[25:9]);
            F_INIT:  return int'(v[8]);
            F_RUN:   return int'(v[7]);
            F_PAUSE: return int'(v[6]);
            F_CLEAR: return int'(v[5]);
            F_MODE:  return int'(v[4:3]);
            F_SEL:   return int'(v[2:1]);
            default: return int'(v[0]);
        endcase
    endfunction

    function automatic int dut_fld(input int k);
        return fld({tar_sec, init_en, run, pause, clear, mode, sel_field, alarm_o}, k);
    endfunction

    task automatic cmp(input string name, input int act_v, input int req_v);
        checks++;
        if (act_v != req_v) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d required %0d", name, $time, act_v, req_v);
        end
    endtask

    // scoreboard: one compare per output per cycle, plus pinned literals
    always @(negedge clk) begin : compare_blk
        logic [W-1:0] e;
        pin_t p;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 8; k++) cmp(fnames[k], dut_fld(k), fld(e, k));
            cmp("one_strobe", int'($countones({init_en, run, pause, clear}) <= 1), 1);
            while (lit_q.size() != 0) begin
                p = lit_q.pop_front();
                cmp(p.name, dut_fld(p.field), p.value);
                cmp({p.name, "_model"}, fld(e, p.field), p.value);
            end
        end
    end

    // driver tasks
    task automatic tick(input logic [5:0] b, input logic buz);
        {btn_clear, btn_pause, btn_start, btn_sel, btn_inc, btn_dec} = b;
        cd_buzzer_i = buz;
        @(posedge clk);
        model_step(rst, b, buz);
        #1;
    endtask

    task automatic pin(input string name, input int field, input int value);
        lit_q.push_back('{name: name, field: field, value: value});
    endtask

    initial begin
        int dens;
        logic [5:0] b;
        logic buz;
        rst = 1'b1;
        tick(B_NONE, 0); tick(B_NONE, 0);
        pin("rst_mode", F_MODE, 0); pin("rst_tar", F_TAR, 0); pin("rst_alarm", F_ALARM, 0);
        rst = 1'b0;

        tick(B_SEL, 0); tick(B_INC, 0); tick(B_INC, 0);
        pin("edit_00_02_00", F_TAR, 120);
        tick(B_SEL, 0); tick(B_INC, 0);
        pin("edit_01_02_00", F_TAR, 3720); pin("edit_sel", F_SEL, 2);

        tick(B_SEL, 0); tick(B_DEC, 0);
        pin("s_wrap_dec", F_TAR, 3779);
        tick(B_SEL, 0); tick(B_SEL, 0); tick(B_DEC, 0); tick(B_DEC, 0);
        pin("h_wrap_dec", F_TAR, 82979);
        tick(B_INC, 0);
        pin("h_wrap_inc", F_TAR, 179);
        tick(B_SEL, 0); tick(B_SEL, 0); tick(B_DEC, 0); tick(B_DEC, 0);
        tick(B_SEL, 0); tick(B_SEL, 0); tick(B_INC, 0);
        pin("zero_tar", F_TAR, 0); pin("zero_sel", F_SEL, 0);
        tick(B_STA, 0);
        pin("start_zero_init", F_INIT, 0); pin("start_zero_mode", F_MODE, 0);
        tick(B_NONE, 0);
        pin("start_zero_run", F_RUN, 0);
        tick(B_NONE, 1);
        pin("buzz_in_set", F_MODE, 0);

        repeat (5) tick(B_INC, 0);
        pin("tar_five", F_TAR, 5);
        tick(B_STA, 0);
        pin("load_init", F_INIT, 1); pin("load_mode", F_MODE, 0);
        tick(B_NONE, 0);
        pin("load_run", F_RUN, 1); pin("run_mode", F_MODE, 1);
        tick(B_PAU, 0);
        pin("pause_strobe", F_PAUSE, 1); pin("paused_mode", F_MODE, 2);
        tick(B_PAU, 0);
        pin("pause_in_paused", F_PAUSE, 0);
        tick(B_STA, 0);
        pin("resume_run", F_RUN, 1); pin("resume_mode", F_MODE, 1);

        tick(B_NONE, 1);
        pin("alarm_mode", F_MODE, 3); pin("alarm_on", F_ALARM, 1);
        repeat (ALARM - 1) tick(B_NONE, 0);
        pin("alarm_hold", F_ALARM, 1);
        tick(B_NONE, 0);
        pin("expire_clear", F_CLEAR, 1); pin("expire_mode", F_MODE, 0); pin("expire_alarm", F_ALARM, 0);
`ifdef AUTO_RELOAD_EN
        tick(B_NONE, 0);
        pin("reload_init", F_INIT, 1);
        tick(B_NONE, 0);
        pin("reload_run", F_RUN, 1); pin("reload_mode", F_MODE, 1);
        tick(B_CLR, 0);
`endif

        tick(B_STA, 0); tick(B_NONE, 0); tick(B_NONE, 1); tick(B_NONE, 0);
        tick(B_INC, 0);
        pin("btn_exit_clear", F_CLEAR, 1); pin("btn_exit_mode", F_MODE, 0); pin("btn_exit_tar", F_TAR, 5);

        tick(B_STA, 0); tick(B_NONE, 0); tick(B_PAU, 0);
        tick(B_CLR | B_STA, 0);
        pin("clr_sta_clear", F_CLEAR, 1); pin("clr_sta_run", F_RUN, 0); pin("clr_sta_mode", F_MODE, 0);

        tick(B_STA, 0); tick(B_NONE, 0);
        tick(B_CLR, 1);
        pin("clr_buzz_mode", F_MODE, 0); pin("clr_buzz_alarm", F_ALARM, 0);
        tick(B_CLR, 0);
        pin("set_clear_keep", F_TAR, 5);

        dens = 8;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) dens = $urandom_range(3, 40);
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < 6; i++) b[i] = ($urandom_range(0, dens - 1) == 0);
            buz = ($urandom_range(0, 9) == 0);
            tick(b, buz);
        end
        rst = 1'b0;
        tick(B_NONE, 0); tick(B_NONE, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
